// File: rtl/mips_mc_pkg.sv
// Purpose: shared state encoding, default widths and owner codes for the memory port arbiter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package mips_mc_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    // Arbiter sequencing: sample requests, drive the memory, acknowledge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // Owner / winner encoding shared by the arbiter and its priority unit.
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LD  = 1'b1;

endpackage

// File: rtl/arb_prio_starve.sv
// Purpose: loader-priority winner select with a CPU starvation counter.
// Latency: winner is combinational; the counter updates on the grant edge.
// Backpressure: none; the caller only uses winner when it issues a grant.
// Ports: clk/rst (async active-low); idle = parent FSM in its sampling state;
//        cpu_req/ld_req = live requests; grant = access granted this cycle;
//        winner = OWNER_LD or OWNER_CPU for the current request pair.
module arb_prio_starve
    import mips_mc_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic cpu_req,
    input  logic ld_req,
    input  logic grant,
    output logic winner
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             cpu_starved;

    // Loader normally wins; a CPU that has watched STARVE_MAX loader grants
    // in a row takes the next slot.
    always_comb begin
        cpu_starved = cpu_req && (starve_cnt_q == CNT_MAX);
        winner      = (ld_req && !cpu_starved) ? OWNER_LD : OWNER_CPU;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (idle && !cpu_req) begin
            // CPU is not waiting, so nothing is being starved.
            starve_cnt_d = '0;
        end else if (grant) begin
            if (winner == OWNER_CPU) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != CNT_MAX) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one synchronous memory port between the CPU datapath and a loader.
// Latency: request sampled at edge N, memory access in cycle N+1, ack and rdata in cycle N+2.
// Backpressure: a losing or waiting requester holds its request; cpu_stall flags a pending CPU.
// Ports: clk, rst (async active-low); cpu_* and ld_* request/ack pairs; mem_* to the RAM
//        (mem_rdata arrives one cycle after the address); rdata valid with ack; owner = last grant.
module mem_port_arbiter
    import mips_mc_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    arb_state_t        state_q,   state_d;
    logic              owner_q,   owner_d;
    logic              mem_we_q,  mem_we_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ld_ack_q,  ld_ack_d;

    logic idle;
    logic grant;
    logic winner;

    assign idle  = (state_q == ST_IDLE);
    assign grant = idle && (cpu_req || ld_req);

    arb_prio_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .idle    (idle),
        .cpu_req (cpu_req),
        .ld_req  (ld_req),
        .grant   (grant),
        .winner  (winner)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_we_d  = 1'b0;
        cpu_ack_d = 1'b0;
        ld_ack_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    // Only these latched values reach the memory.
                    owner_d = winner;
                    if (winner == OWNER_LD) begin
                        mem_we_d = ld_we;
                        addr_d   = ld_addr;
                        wdata_d  = ld_wdata;
                    end else begin
                        mem_we_d = cpu_we;
                        addr_d   = cpu_addr;
                        wdata_d  = cpu_wdata;
                    end
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                cpu_ack_d = (owner_q == OWNER_CPU);
                ld_ack_d  = (owner_q == OWNER_LD);
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                // RAM output is stable through DONE; keep it so rdata holds until the next ack.
                rdata_d = mem_rdata;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_CPU;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cpu_ack_q <= 1'b0;
            ld_ack_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cpu_ack_q <= cpu_ack_d;
            ld_ack_q  <= ld_ack_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign owner     = owner_q;
    assign cpu_ack   = cpu_ack_q;
    assign ld_ack    = ld_ack_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;
    // The RAM answers in the ack cycle itself, so pass it through there and
    // show the held copy at all other times.
    assign rdata     = (state_q == ST_DONE) ? mem_rdata : rdata_q;

endmodule
